// File: rtl/bpu_pkg.sv
// Shared branch-prediction types for the fetch front end and the predictor.
// Holds the PC width, the per-stage prediction tracker entry and the next-PC select encoding.
// Ports: none (package).
package bpu_pkg;

  localparam int PC_W = 32;

  // One in-flight prediction, carried alongside the instruction it was made for.
  typedef struct packed {
    logic            valid;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
  } trk_entry_t;

  typedef enum logic [1:0] {
    NPC_RESTORE,
    NPC_HOLD,
    NPC_PRED,
    NPC_SEQ
  } npc_sel_t;

  // Next-PC source, highest priority first: repair, freeze, predicted redirect, sequential.
  function automatic npc_sel_t npc_select(input logic mispredict,
                                          input logic hold,
                                          input logic pred_taken);
    npc_sel_t sel;
    if (mispredict)      sel = NPC_RESTORE;
    else if (hold)       sel = NPC_HOLD;
    else if (pred_taken) sel = NPC_PRED;
    else                 sel = NPC_SEQ;
    return sel;
  endfunction

endpackage

// File: rtl/fetch_pc_if.sv
// Front-end bundle between the fetch PC block and its neighbours (predictor, pipeline, imem).
// master: the pipeline/predictor side that drives predictions and resolutions.
// slave: the fetch PC block view; it returns the fetch address, flush and statistics.
interface fetch_pc_if #(
  parameter int PC = bpu_pkg::PC_W
);
  logic          stall_in;
  logic          fetch_prediction_in;
  logic [PC-1:0] pc_prediction_in;
  logic          exmem_jmp_br_in;
  logic          exmem_pc_src_in;
  logic [PC-1:0] exmem_pc_branch_in;
  logic [PC-1:0] pc_restore_in;
  logic [PC-1:0] fetch_pc_out;
  logic          fetch_valid_out;
  logic          flush_out;
  logic          mispredict_out;
  logic [31:0]   branch_count_out;
  logic [31:0]   mispredict_count_out;

  modport master (
    output stall_in, fetch_prediction_in, pc_prediction_in, exmem_jmp_br_in,
           exmem_pc_src_in, exmem_pc_branch_in, pc_restore_in,
    input  fetch_pc_out, fetch_valid_out, flush_out, mispredict_out,
           branch_count_out, mispredict_count_out
  );

  modport slave (
    input  stall_in, fetch_prediction_in, pc_prediction_in, exmem_jmp_br_in,
           exmem_pc_src_in, exmem_pc_branch_in, pc_restore_in,
    output fetch_pc_out, fetch_valid_out, flush_out, mispredict_out,
           branch_count_out, mispredict_count_out
  );
endinterface

// File: rtl/pred_tracker.sv
// Three-deep shift register (IF/ID, ID/EX, EX/MEM) of predictions made at fetch.
// Ports: clk_in/nrst_in; shift_en advances one stage, clear drops all entries (wins over shift),
// load_entry enters at IF/ID, exmem_entry is the prediction for the instruction now resolving.
module pred_tracker
  import bpu_pkg::*;
(
  input  logic       clk_in,
  input  logic       nrst_in,
  input  logic       shift_en,
  input  logic       clear,
  input  trk_entry_t load_entry,
  output trk_entry_t exmem_entry
);

  trk_entry_t if_id_q;
  trk_entry_t id_ex_q;
  trk_entry_t ex_mem_q;

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      if_id_q  <= '0;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
    end else if (clear) begin
      // Everything younger than the mispredicted branch is wrong-path, including this fetch.
      if_id_q  <= '0;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
    end else if (shift_en) begin
      if_id_q  <= load_entry;
      id_ex_q  <= if_id_q;
      ex_mem_q <= id_ex_q;
    end
  end

  assign exmem_entry = ex_mem_q;

endmodule

// File: rtl/fetch_pc.sv
// Fetch PC register with prediction tracking, misprediction repair and branch statistics.
// Ports: clk_in/nrst_in; stall_in freezes; fetch_prediction_in/pc_prediction_in steer fetch;
// exmem_* resolve the oldest tracked branch; outputs are fetch PC/valid, flush, mispredict, counters.
module fetch_pc
  import bpu_pkg::*;
#(
  parameter int            PC           = 32,
  parameter logic [PC-1:0] RESET_VECTOR = '0
) (
  input  logic          clk_in,
  input  logic          nrst_in,
  input  logic          stall_in,
  input  logic          fetch_prediction_in,
  input  logic [PC-1:0] pc_prediction_in,
  input  logic          exmem_jmp_br_in,
  input  logic          exmem_pc_src_in,
  input  logic [PC-1:0] exmem_pc_branch_in,
  input  logic [PC-1:0] pc_restore_in,
  output logic [PC-1:0] fetch_pc_out,
  output logic          fetch_valid_out,
  output logic          flush_out,
  output logic          mispredict_out,
  output logic [31:0]   branch_count_out,
  output logic [31:0]   mispredict_count_out
);

  logic          live_q;
  logic [PC-1:0] pc_q;
  logic [31:0]   branch_cnt_q;
  logic [31:0]   mispredict_cnt_q;

  trk_entry_t    load_entry;
  trk_entry_t    s3;
  logic          actual_taken;
  logic          mispredict;
  logic          branch_resolved;
  logic          advance;
  npc_sel_t      npc_sel;
  logic [PC-1:0] npc_raw;
  logic [PC-1:0] npc;

  // live_q stays low for the first edge after reset so RESET_VECTOR is presented as a live fetch.
  assign advance = live_q & ~stall_in;

  always_comb begin
    load_entry             = '0;
    load_entry.valid       = 1'b1;
    load_entry.pred_taken  = fetch_prediction_in;
    load_entry.pred_target = PC_W'(pc_prediction_in);
  end

  pred_tracker u_pred_tracker (
    .clk_in      (clk_in),
    .nrst_in     (nrst_in),
    .shift_en    (advance),
    .clear       (mispredict),
    .load_entry  (load_entry),
    .exmem_entry (s3)
  );

  // A predicted-taken slot that turns out not to be a branch (predictor alias) compares as
  // taken vs. not-taken, so it is caught by the direction check.
  assign actual_taken    = exmem_jmp_br_in & exmem_pc_src_in;
  assign mispredict      = ~stall_in & s3.valid &
                           ((s3.pred_taken != actual_taken) |
                            (s3.pred_taken & actual_taken &
                             (s3.pred_target != PC_W'(exmem_pc_branch_in))));
  assign branch_resolved = ~stall_in & s3.valid & exmem_jmp_br_in;

  always_comb begin
    npc_sel = npc_select(mispredict, stall_in | ~live_q, fetch_prediction_in);
    case (npc_sel)
      NPC_RESTORE: npc_raw = pc_restore_in;
      NPC_HOLD:    npc_raw = pc_q;
      NPC_PRED:    npc_raw = pc_prediction_in;
      default:     npc_raw = pc_q + PC'(4);
    endcase
    npc = {npc_raw[PC-1:2], 2'b00};
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      live_q           <= 1'b0;
      pc_q             <= RESET_VECTOR;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      live_q <= 1'b1;
      pc_q   <= npc;
      if (branch_resolved && branch_cnt_q != 32'hFFFF_FFFF)
        branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mispredict && mispredict_cnt_q != 32'hFFFF_FFFF)
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  assign fetch_pc_out         = pc_q;
  assign fetch_valid_out      = live_q & ~mispredict;
  assign flush_out            = mispredict;
  assign mispredict_out       = mispredict;
  assign branch_count_out     = branch_cnt_q;
  assign mispredict_count_out = mispredict_cnt_q;

endmodule
